// File: rtl/osd_regaccess_responder_pkg.sv
// ==========================================================================
// osd_regaccess_pkg : shared constants and FSM state type for the
//                     register-access responder.       rev 1.0
// ==========================================================================
`default_nettype none

package osd_regaccess_pkg;

  localparam logic [1:0]  TYPE_REG       = 2'b00;

  localparam logic [3:0]  REQ_READ       = 4'h0;
  localparam logic [3:0]  REQ_WRITE      = 4'h1;
  localparam logic [3:0]  RESP_READ_OK   = 4'h8;
  localparam logic [3:0]  RESP_READ_ERR  = 4'h9;
  localparam logic [3:0]  RESP_WRITE_OK  = 4'hA;
  localparam logic [3:0]  RESP_WRITE_ERR = 4'hB;

  localparam logic [15:0] REG_MOD_VENDOR  = 16'h0000;
  localparam logic [15:0] REG_MOD_TYPE    = 16'h0001;
  localparam logic [15:0] REG_MOD_VERSION = 16'h0002;

  typedef enum logic [3:0] {
    ST_RX_DEST,
    ST_RX_SRC,
    ST_RX_HDR,
    ST_RX_ADDR,
    ST_RX_WDATA,
    ST_RX_DRAIN,
    ST_ACCESS,
    ST_TX_DEST,
    ST_TX_SRC,
    ST_TX_HDR,
    ST_TX_DATA
  } state_t;

  // Identity registers occupy the bottom of the address map.
  function automatic logic is_base_reg(input logic [15:0] addr);
    return addr <= REG_MOD_VERSION;
  endfunction

endpackage

`default_nettype wire

// File: rtl/osd_regaccess_responder_if.sv
// ==========================================================================
// dii_channel : 16-bit debug interconnect packet channel with
//               first/last framing and valid/ready flow control. rev 1.0
// ==========================================================================
`default_nettype none

interface dii_channel;
  logic [15:0] data;
  logic        valid;
  logic        first;
  logic        last;
  logic        ready;

  modport master (output data, output valid, output first, output last, input ready);
  modport slave  (input data, input valid, input first, input last, output ready);
endinterface

`default_nettype wire

// File: rtl/osd_regaccess_responder.sv
// ==========================================================================
// osd_regaccess_responder : answers DII register-access requests, serving
//                           identity registers and forwarding the rest. rev 1.0
// ==========================================================================
`default_nettype none

module osd_regaccess_responder
  import osd_regaccess_pkg::*;
#(
  parameter logic [15:0] MOD_VENDOR  = 16'h0001,
  parameter logic [15:0] MOD_TYPE    = 16'h0000,
  parameter logic [15:0] MOD_VERSION = 16'h0000
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic [15:0] id,
  dii_channel.slave        dii_in,
  dii_channel.master       dii_out,
  output logic             reg_request,
  output logic             reg_write,
  output logic [15:0]      reg_addr,
  output logic [15:0]      reg_wdata,
  input  wire logic        reg_ack,
  input  wire logic        reg_err,
  input  wire logic [15:0] reg_rdata
);

  state_t      r_state;
  logic [15:0] r_src;
  logic [3:0]  r_sub;
  logic [15:0] r_rdata;
  logic        r_req;
  logic        r_write;
  logic [15:0] r_addr;
  logic [15:0] r_wdata;
  logic        r_respond;

  logic        w_in_ready;
  logic        w_out_valid;
  logic        w_in_hs;
  logic        w_out_hs;
  logic        w_hdr_ok;
  logic [15:0] w_tx_data;
  logic [15:0] w_base_val;

  assign w_in_ready  = (r_state == ST_RX_DEST) || (r_state == ST_RX_SRC) ||
                       (r_state == ST_RX_HDR)  || (r_state == ST_RX_ADDR) ||
                       (r_state == ST_RX_WDATA) || (r_state == ST_RX_DRAIN);
  assign w_out_valid = (r_state == ST_TX_DEST) || (r_state == ST_TX_SRC) ||
                       (r_state == ST_TX_HDR)  || (r_state == ST_TX_DATA);
  assign w_in_hs     = dii_in.valid & w_in_ready;
  assign w_out_hs    = w_out_valid & dii_out.ready;
  assign w_hdr_ok    = (dii_in.data[15:14] == TYPE_REG) &&
                       ((dii_in.data[13:10] == REQ_READ) || (dii_in.data[13:10] == REQ_WRITE));

  always_comb begin
    w_tx_data = 16'h0000;
    case (r_state)
      ST_TX_DEST: w_tx_data = r_src;
      ST_TX_SRC:  w_tx_data = id;
      ST_TX_HDR:  w_tx_data = {TYPE_REG, r_sub, 10'h000};
      ST_TX_DATA: w_tx_data = r_rdata;
      default:    w_tx_data = 16'h0000;
    endcase
  end

  always_comb begin
    w_base_val = MOD_VERSION;
    case (r_addr[1:0])
      2'd0:    w_base_val = MOD_VENDOR;
      2'd1:    w_base_val = MOD_TYPE;
      default: w_base_val = MOD_VERSION;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_RX_DEST;
      r_src     <= 16'h0000;
      r_sub     <= 4'h0;
      r_rdata   <= 16'h0000;
      r_req     <= 1'b0;
      r_write   <= 1'b0;
      r_addr    <= 16'h0000;
      r_wdata   <= 16'h0000;
      r_respond <= 1'b0;
    end else begin
      case (r_state)
        ST_RX_DEST: if (w_in_hs && dii_in.first && !dii_in.last) r_state <= ST_RX_SRC;
        ST_RX_SRC: if (w_in_hs) begin
          r_src   <= dii_in.data;
          r_state <= dii_in.last ? ST_RX_DEST : ST_RX_HDR;
        end
        ST_RX_HDR: if (w_in_hs) begin
          if (dii_in.last) begin
            r_state <= ST_RX_DEST;
          end else if (!w_hdr_ok) begin
            r_respond <= 1'b0;
            r_state   <= ST_RX_DRAIN;
          end else begin
            r_write <= (dii_in.data[13:10] == REQ_WRITE);
            r_state <= ST_RX_ADDR;
          end
        end
        ST_RX_ADDR: if (w_in_hs) begin
          r_addr <= dii_in.data;
          if (!r_write) begin
            if (dii_in.last) begin
              r_req   <= !is_base_reg(dii_in.data);
              r_state <= ST_ACCESS;
            end else begin
              r_sub     <= RESP_READ_ERR;
              r_respond <= 1'b1;
              r_state   <= ST_RX_DRAIN;
            end
          end else if (dii_in.last) begin
            r_sub   <= RESP_WRITE_ERR;
            r_state <= ST_TX_DEST;
          end else begin
            r_state <= ST_RX_WDATA;
          end
        end
        ST_RX_WDATA: if (w_in_hs) begin
          r_wdata <= dii_in.data;
          if (dii_in.last) begin
            r_req   <= !is_base_reg(r_addr);
            r_state <= ST_ACCESS;
          end else begin
            r_sub     <= RESP_WRITE_ERR;
            r_respond <= 1'b1;
            r_state   <= ST_RX_DRAIN;
          end
        end
        ST_RX_DRAIN: if (w_in_hs && dii_in.last) r_state <= r_respond ? ST_TX_DEST : ST_RX_DEST;
        ST_ACCESS: begin
          // Identity registers are read-only and answered without a module access.
          if (r_req) begin
            if (reg_ack) begin
              r_req   <= 1'b0;
              r_rdata <= reg_rdata;
              if (r_write) r_sub <= reg_err ? RESP_WRITE_ERR : RESP_WRITE_OK;
              else         r_sub <= reg_err ? RESP_READ_ERR  : RESP_READ_OK;
              r_state <= ST_TX_DEST;
            end
          end else begin
            if (r_write) begin
              r_sub <= RESP_WRITE_ERR;
            end else begin
              r_sub   <= RESP_READ_OK;
              r_rdata <= w_base_val;
            end
            r_state <= ST_TX_DEST;
          end
        end
        ST_TX_DEST: if (w_out_hs) r_state <= ST_TX_SRC;
        ST_TX_SRC:  if (w_out_hs) r_state <= ST_TX_HDR;
        ST_TX_HDR:  if (w_out_hs) r_state <= (r_sub == RESP_READ_OK) ? ST_TX_DATA : ST_RX_DEST;
        ST_TX_DATA: if (w_out_hs) r_state <= ST_RX_DEST;
        default:    r_state <= ST_RX_DEST;
      endcase
    end
  end

  assign dii_in.ready  = w_in_ready;
  assign dii_out.valid = w_out_valid;
  assign dii_out.data  = w_tx_data;
  assign dii_out.first = (r_state == ST_TX_DEST);
  assign dii_out.last  = (r_state == ST_TX_DATA) ||
                         ((r_state == ST_TX_HDR) && (r_sub != RESP_READ_OK));

  assign reg_request = r_req;
  assign reg_write   = r_write;
  assign reg_addr    = r_addr;
  assign reg_wdata   = r_wdata;

endmodule

`default_nettype wire

// File: doc/osd_regaccess_responder.md
Name: osd_regaccess_responder

Overview:
DII-side endpoint that answers register-access request packets injected into the debug interconnect by the host interface (GLIP-to-DII) path.
- Receives one request packet on dii_in, decodes it, and serves three identity registers internally.
- Forwards all other addresses to a simple request/acknowledge register port on the owning debug module.
- Returns exactly one response packet on dii_out per valid request.
- Sits between the debug ring/router and one debug module.

Parameters:
MOD_VENDOR, 16'h0001, value returned for register address 16'h0000
MOD_TYPE, 16'h0000, value returned for register address 16'h0001
MOD_VERSION, 16'h0000, value returned for register address 16'h0002

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
id  input  16  own module address; used as source address in responses
dii_in  dii_channel.slave  16+4  request packets (data[15:0], valid, first, last, ready)
dii_out  dii_channel.master  16+4  response packets
reg_request  output  1  module register access pending
reg_write  output  1  1 = write, 0 = read; stable while reg_request
reg_addr  output  16  register address
reg_wdata  output  16  write data
reg_ack  input  1  access done, one-cycle pulse
reg_err  input  1  sampled with reg_ack; 1 = access failed
reg_rdata  input  16  read data, sampled with reg_ack

Behaviour:
- Packet format, 16-bit words:
  - w0 destination
  - w1 source
  - w2 header: [15:14] type, 2'b00 = REG; [13:10] subtype; [9:0] zero
  - w3 address
  - w4 write data (writes only)
- Request subtypes: 0x0 read, 0x1 write.
- Response subtypes: 0x8 read ok, 0x9 read error, 0xA write ok, 0xB write error.
- Response packet: w0 = request source, w1 = id, w2 = {2'b00, subtype, 10'h0}, w3 = read data (read ok only).
- FSM states: RX_DEST, RX_SRC, RX_HDR, RX_ADDR, RX_WDATA, RX_DRAIN, ACCESS, TX_DEST, TX_SRC, TX_HDR, TX_DATA.
- dii_in.ready = 1 exactly in RX_* states.
- dii_out.valid = 1 exactly in TX_* states.
- dii_out.first = 1 in TX_DEST only.
- dii_out.last = 1 on the final response word.
- Words advance only on valid&ready. The output holds data and flags stable while valid&!ready.
- RX_DEST: words with first=0 are discarded.
- Early last (at w0..w2): drop the packet silently and return to RX_DEST.
- Header type != REG, or subtype not 0x0/0x1: go to RX_DRAIN without last, or straight to RX_DEST with last. No response.
- Read request:
  - Length exactly 4 words → ACCESS.
  - Longer → RX_DRAIN, then read error response.
  - Shorter (last at w3 is impossible here) → no special case.
- Write request:
  - Last at w3 → write error response.
  - Length exactly 5 → ACCESS.
  - Longer → drain, then write error response.
- ACCESS, address 0x0000–0x0002:
  - Read: ok response with the parameter value, no reg_request.
  - Write: write error response.
  - Next cycle goes to TX_DEST.
- ACCESS, other addresses:
  - reg_request = 1 with reg_write/reg_addr/reg_wdata stable until the cycle reg_ack = 1, then deasserted the next cycle.
  - Latency on reg_ack is unbounded; no timeout.
  - reg_ack and reg_err are sampled only in ACCESS.
  - reg_ack with reg_err = 1 → error subtype.
- TX_DATA is skipped for all responses except read ok.
- After the last response word handshakes → RX_DEST. No new request is accepted before then (one outstanding request).
- Minimum turnaround: 1 cycle from request last to response first when serving internal registers.
- Reset:
  - Values: state = RX_DEST; dii_in.ready = 1, dii_out.valid = 0, reg_request = 0, reg_write = 0, reg_addr = 0, reg_wdata = 0.
  - Mid-operation reset abandons any partial request or response without emitting further words.
  - An assertion of reg_ack after reset is ignored.

Decomposition:
- Shared package osd_regaccess_pkg holds:
  - type constant TYPE_REG = 2'b00;
  - subtype constants REQ_READ = 4'h0, REQ_WRITE = 4'h1, RESP_READ_OK = 4'h8, RESP_READ_ERR = 4'h9, RESP_WRITE_OK = 4'hA, RESP_WRITE_ERR = 4'hB;
  - base register addresses REG_MOD_VENDOR/TYPE/VERSION = 16'h0000/0001/0002;
  - an enum for the FSM state.
- Single module, no sub-module; the RX and TX word counters fold into FSM states.

Test Plan:
- id = 16'h0005, read packet {0005, 0001, 0000, 0000} → response {0001, 0005, 2000, MOD_VENDOR}, first on w0, last on w3, no reg_request.
- Read of 16'h0200, reg_ack after 3 cycles with rdata = 16'hBEEF → reg_request held 3 cycles with reg_write = 0, reg_addr = 0200; response {0001, 0005, 2000, BEEF}.
- Write {0005, 0001, 0400, 0210, 1234}, reg_ack with reg_err = 1 → reg_wdata = 1234, reg_write = 1; response {0001, 0005, 2C00}, 3 words.
- Write to 16'h0001 → no reg_request; response header 2C00. Read packet with 5 words → fifth word drained; response header 2400, 3 words.
- Header 16'h4000 (non-REG, 6 words) → all words consumed, dii_out.valid never asserted; a following read is answered normally.
- dii_out.ready = 0 for 4 cycles mid-response → words held stable, no loss or duplication. rst asserted during ACCESS → reg_request = 0 and dii_out.valid = 0 next cycle; a new read is answered correctly.
